// File: rtl/uart_cmd_arbiter.sv
// Two-client round-robin arbiter that turns client operations into timed UART
// command strobes (id/din/write), with TX-full store stall and sample-then-pop reads.
module uart_cmd_arbiter #(
  parameter int TX_LIMIT = 1024,
  parameter int POP_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata,
  output logic        rempty,
  output logic        busy,
  output logic [15:0] uart_id,
  output logic [15:0] uart_din,
  output logic        uart_write,
  input  logic [7:0]  uart_dout,
  input  logic [11:0] uart_rxcount,
  input  logic [11:0] uart_txcount,
  output logic [2:0]  o_dbg_state
);

  // Client handshake: reqN is held with opN/wdataN stable until a one-cycle
  // doneN pulse; req is only sampled in IDLE, so the client must drop it (or
  // present a new op) in the cycle after done.

  localparam logic [11:0] TX_LIM = 12'(TX_LIMIT);
  localparam int          WAIT_W = $clog2(POP_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POP_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_RDCHK  = 3'd2,
    S_RDPOP  = 3'd3,
    S_RDWAIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_client;
  logic                r_last;
  logic [2:0]          r_op;
  logic [15:0]         r_wdata;
  logic [WAIT_W-1:0]   r_wait;
  logic [7:0]          r_rdata;
  logic                r_rempty;
  logic [15:0]         r_id;
  logic [15:0]         r_din;

  logic                w_grant;
  logic                w_start;
  logic [2:0]          w_gop;
  logic                w_write;
  logic                w_done;
  logic [15:0]         w_cmd_id;
  logic [15:0]         w_cmd_din;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_start     = 1'b0;
    w_write     = 1'b0;
    w_done      = 1'b0;
    w_cmd_id    = 16'h0000;
    w_cmd_din   = 16'h0000;
    // On a tie the client not granted last wins; a lone request wins outright.
    w_grant     = (req0 && req1) ? ~r_last : req1;
    w_gop       = w_grant ? op1 : op0;

    case (r_state)
      S_IDLE: begin
        w_start = req0 || req1;
        if (w_start) begin
          case (w_gop)
            3'd4:       w_state_nxt = S_RDCHK;
            3'd6, 3'd7: w_state_nxt = S_DONE;
            default:    w_state_nxt = S_ISSUE;
          endcase
        end
      end
      S_ISSUE: begin
        w_cmd_id = 16'h0200 + {13'h0000, r_op};
        case (r_op)
          3'd0:    w_cmd_din = r_wdata;
          3'd1:    w_cmd_din = {8'h00, r_wdata[7:0]};
          default: w_cmd_din = 16'h0000;
        endcase
        // Stores wait here while the TX buffer is at its limit.
        if (!(r_op == 3'd1 && uart_txcount >= TX_LIM)) begin
          w_write     = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_RDCHK: begin
        w_state_nxt = (uart_rxcount == 12'd0) ? S_DONE : S_RDPOP;
      end
      S_RDPOP: begin
        w_cmd_id    = 16'h0204;
        w_write     = 1'b1;
        w_state_nxt = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (r_wait == WAIT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_client <= 1'b0;
      r_last   <= 1'b1;
      r_op     <= 3'd0;
      r_wdata  <= 16'h0000;
      r_wait   <= '0;
      r_rdata  <= 8'h00;
      r_rempty <= 1'b0;
      r_id     <= 16'h0000;
      r_din    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_start) begin
        r_client <= w_grant;
        r_last   <= w_grant;
        r_op     <= w_gop;
        r_wdata  <= w_grant ? wdata1 : wdata0;
      end
      if (w_write) begin
        r_id  <= w_cmd_id;
        r_din <= w_cmd_din;
      end
      if (r_state == S_RDCHK && uart_rxcount == 12'd0) r_rempty <= 1'b1;
      // Sample the head byte in the same cycle the pop command is strobed.
      if (r_state == S_RDPOP) begin
        r_rdata  <= uart_dout;
        r_rempty <= 1'b0;
        r_wait   <= '0;
      end else if (r_state == S_RDWAIT) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign uart_write  = w_write;
  assign uart_id     = w_write ? w_cmd_id  : r_id;
  assign uart_din    = w_write ? w_cmd_din : r_din;
  assign done0       = w_done && !r_client;
  assign done1       = w_done &&  r_client;
  assign rdata       = r_rdata;
  assign rempty      = r_rempty;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/uart_cmd_arbiter.md
# uart_cmd_arbiter

Two-client command arbiter and sequencer for the UART command bus (id/din/write). It grants the bus to one client at a time using round-robin priority. Each client operation is turned into correctly timed UART commands. Transmit stores are held off while the TX buffer is at its limit, and each receive read is a single sample-then-pop transaction. The block sits between the CPU-side register decoder (client 0) and the debug/loader engine (client 1) on one side, and the UART instance on the other.

## Interface
- TX_LIMIT, 1024: store ops stall while uart_txcount >= TX_LIMIT; prevents the UART from overwriting its oldest byte.
- POP_WAIT, 3: idle cycles after an rxNextByte write before the next UART command; minimum 3.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- req0 / req1  in  1  client request; held with op/wdata stable until the matching done
- op0 / op1  in  3  0 setBaud, 1 store, 2 flush, 3 txPurge, 4 read, 5 rxPurge; 6/7 illegal
- wdata0 / wdata1  in  16  baud divisor (op 0) or byte in [7:0] (op 1); ignored otherwise
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  8  read byte; valid in the done cycle of a read, held until the next read
- rempty  out  1  1 if the last read found uart_rxcount==0; valid with done
- busy  out  1  high whenever state != IDLE
- uart_id  out  16  command id to the UART
- uart_din  out  16  command data to the UART
- uart_write  out  1  command strobe, one cycle per command
- uart_dout  in  8  UART RX head byte
- uart_rxcount  in  12  UART RX occupancy
- uart_txcount  in  12  UART TX occupancy

## Operation
- Reset values: uart_write 0, uart_id 0x0000, uart_din 0x0000, done0/1 0, rdata 0x00, rempty 0, busy 0. State is IDLE and the RR pointer favours client 0.
- FSM states: IDLE, ISSUE, RDCHK, RDPOP, RDWAIT, DONE.
- IDLE, arbitration:
  - If only one req is high, grant that client.
  - If both are high, grant the client not granted last; after reset, client 0 wins.
  - Latch the granted op, wdata and client index, then update the RR pointer.
  - Op 4 goes to RDCHK; ops 0-3 and 5 go to ISSUE; ops 6/7 go to DONE directly with no UART command.
- ISSUE:
  - uart_id = 0x0200 + op.
  - uart_din = wdata for op 0, {8'h00, wdata[7:0]} for op 1, 0 otherwise.
  - uart_write = 1 for this cycle only, then go to DONE.
  - Store stall: for op 1 with uart_txcount >= TX_LIMIT, stay in ISSUE with uart_write = 0 until uart_txcount < TX_LIMIT.
  - Flush with uart_txcount == 0: still issued (UART ignores it), no special case.
- RDCHK:
  - If uart_rxcount == 0: rempty <= 1, go to DONE; no UART command.
  - Otherwise go to RDPOP.
- RDPOP: rdata <= uart_dout, rempty <= 0, uart_id = 0x0204, uart_write = 1 for one cycle, then go to RDWAIT.
- RDWAIT: count POP_WAIT cycles with uart_write = 0, then go to DONE. This covers the UART's delayed head-pointer increment, rxcount decrement and RAM read latency.
- DONE: pulse done for the granted client only, then go to IDLE.
- uart_id/uart_din hold their last value when uart_write = 0; only uart_write qualifies them.
- A client must drop req the cycle after its done unless it has a new request. req is only sampled in IDLE.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No done is issued, and the aborted op is not retried. A command already strobed stays in effect; no compensating purge is issued.
- The block never drives the UART reset. uart_rxcount/txcount are treated as synchronous to clk.

## Timing
- Simple op, req sampled in cycle T:
  - T+1: ISSUE, uart_write high.
  - T+2: DONE.
  - T+3: IDLE; next grant decided in T+3.
- Read with data: RDCHK T+1, RDPOP T+2 (write), RDWAIT T+3..T+2+POP_WAIT, done at T+3+POP_WAIT (T+6 by default).
- Read empty: done at T+2 with rempty = 1.
- Illegal op: done at T+1.
- Consecutive uart_write strobes are always separated by at least 2 idle cycles. After a pop the separation is at least POP_WAIT+2.
- Back-to-back ops from alternating clients: one op per 3 cycles (simple ops).

## Test plan
- Reset, then client 0 op 0 with wdata=0x0516 → uart_id=0x0200, uart_din=0x0516, one write at T+1, done0 at T+2, done1 never.
- Both reqs asserted continuously with op 1 (bytes 0xA5 from client 0, 0x3C from client 1) → grants alternate 0,1,0,1. Store strobes are 3 cycles apart with uart_din[7:0] matching each client.
- uart_txcount=1024 with client 1 op 1 → no write, busy high. Drop txcount to 1023 → write the next ISSUE cycle, done1 the cycle after.
- uart_rxcount=2 and uart_dout=0x41, client 0 op 4 → rdata=0x41, rempty=0, single write id 0x0204 at T+2, done0 at T+6. With uart_rxcount=0 → done0 at T+2, rempty=1, no write.
- Assert reset in RDWAIT and in stalled ISSUE → IDLE next cycle, uart_write 0, no done pulse. Then simultaneous reqs → client 0 granted first.
